// File: rtl/calc_display_pkg.sv
// Shared types, segment constants and helpers for the result display stage.
package calc_display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        DONE
    } disp_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ZERO  = 7'h40;

    // Active-low {g,f,e,d,c,b,a} pattern for a BCD nibble; non-decimal codes blank.
    function automatic logic [6:0] seg7_of(input logic [3:0] nibble);
        logic [6:0] s;
        case (nibble)
            4'd0:    s = SEG_ZERO;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // 10^e, used only for the elaboration-time digit-count check.
    function automatic longint unsigned pow10(input int unsigned e);
        longint unsigned p;
        p = 64'd1;
        for (int unsigned i = 0; i < e; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/result_bcd_display_bcd_to_seg7.sv
// Combinational decode of the selected BCD digit, with forced blanking.
module bcd_to_seg7
    import calc_display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    // Blanking overrides the digit pattern.
    always_comb begin
        seg = blank ? SEG_BLANK : seg7_of(nibble);
    end

endmodule

// File: rtl/result_bcd_display.sv
// Result capture, iterative double-dabble BCD conversion and multiplexed
// active-low 7-segment display with leading-zero blanking.
module result_bcd_display
    import calc_display_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned DIGITS   = 3,
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [2*N-1:0]      resultado,
    input  logic [3:0]          banderas,
    output logic                busy,
    output logic [6:0]          seg,
    output logic [DIGITS-1:0]   an,
    output logic [3:0]          leds
);

    localparam int unsigned RW   = 2 * N;
    localparam int unsigned BW   = 4 * DIGITS;
    localparam int unsigned CW   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned ITW  = $clog2(RW + 1);

    if (pow10(DIGITS) <= ((64'd1 << RW) - 64'd1)) begin : g_digits_too_few
        $error("DIGITS too small to display a %0d-bit result", RW);
    end
    if (SCAN_DIV < 2) begin : g_scan_div_too_small
        $error("SCAN_DIV must be at least 2");
    end

    disp_state_t      state;
    logic [RW-1:0]    bin_sr;
    logic [BW-1:0]    bcd_sr;
    logic [BW-1:0]    bcd_adj;
    logic [BW-1:0]    disp_val;
    logic [3:0]       flag_hold;
    logic [ITW-1:0]   iter;

    logic [CW-1:0]    scan_cnt;
    logic [IW-1:0]    idx;
    logic [3:0]       sel_nib;
    logic             sel_blank;
    logic [6:0]       seg_next;

    // Add-3 correction on every nibble that is 5 or more; no inter-nibble carry.
    always_comb begin
        bcd_adj = bcd_sr;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (bcd_sr[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_sr[4*k +: 4] + 4'd3;
            end
        end
    end

    // Capture / convert / commit sequencer; display and LEDs update only on commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bin_sr    <= '0;
            bcd_sr    <= '0;
            iter      <= '0;
            flag_hold <= '0;
            disp_val  <= '0;
            leds      <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        bin_sr    <= resultado;
                        flag_hold <= banderas;
                        bcd_sr    <= '0;
                        iter      <= '0;
                        busy      <= 1'b1;
                        state     <= CONVERT;
                    end
                end
                CONVERT: begin
                    bcd_sr <= {bcd_adj[BW-2:0], bin_sr[RW-1]};
                    bin_sr <= {bin_sr[RW-2:0], 1'b0};
                    iter   <= iter + 1'b1;
                    if (iter == ITW'(RW - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    disp_val <= bcd_sr;
                    leds     <= flag_hold;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Select the scanned digit and decide whether it is a leading zero.
    always_comb begin
        sel_nib   = '0;
        sel_blank = (idx != '0);
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (idx == IW'(k)) begin
                sel_nib = disp_val[4*k +: 4];
            end
            if ((k >= 32'(idx)) && (disp_val[4*k +: 4] != 4'd0)) begin
                sel_blank = 1'b0;
            end
        end
    end

    bcd_to_seg7 u_dec (
        .nibble (sel_nib),
        .blank  (sel_blank),
        .seg    (seg_next)
    );

    // Free-running scan: dwell SCAN_DIV cycles per digit, registered an/seg.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            idx      <= '0;
            an       <= '1;
            seg      <= SEG_BLANK;
        end else begin
            an  <= ~(DIGITS'(1) << idx);
            seg <= seg_next;
            if (scan_cnt == CW'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                idx      <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_result_bcd_display.sv
// Scoreboard bench for result_bcd_display (N=4, DIGITS=3, SCAN_DIV=4).
module tb_result_bcd_display;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load;
    logic [7:0] resultado;
    logic [3:0] banderas;
    logic       busy;
    logic [6:0] seg;
    logic [2:0] an;
    logic [3:0] leds;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [3:0] leds;
        logic [6:0] s2;
        logic [6:0] s1;
        logic [6:0] s0;
        bit         chk_disp;
    } exp_t;

    exp_t sbq[$];

    result_bcd_display #(
        .N        (4),
        .DIGITS   (3),
        .SCAN_DIV (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .resultado (resultado),
        .banderas  (banderas),
        .busy      (busy),
        .seg       (seg),
        .an        (an),
        .leds      (leds)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic do_load(input logic [7:0] v, input logic [3:0] f);
        @(negedge clk);
        load      = 1'b1;
        resultado = v;
        banderas  = f;
        @(negedge clk);
        load      = 1'b0;
    endtask

    task automatic push_exp(input logic [3:0] l, input logic [6:0] s2, input logic [6:0] s1,
                            input logic [6:0] s0, input bit c);
        exp_t e;
        e.leds = l; e.s2 = s2; e.s1 = s1; e.s0 = s0; e.chk_disp = c;
        sbq.push_back(e);
    endtask

    // Monitor: on each commit (busy falling) pop and check busy length, LEDs, display.
    initial begin : monitor
        int         bcnt;
        int         left;
        exp_t       cur;
        logic [6:0] cap [3];
        logic [2:0] seen;
        bcnt = 0;
        left = 0;
        seen = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bcnt = 0;
                left = 0;
            end else begin
                if (left > 0) begin
                    case (an)
                        3'b110:  begin cap[0] = seg; seen[0] = 1'b1; end
                        3'b101:  begin cap[1] = seg; seen[1] = 1'b1; end
                        3'b011:  begin cap[2] = seg; seen[2] = 1'b1; end
                        default: ;
                    endcase
                    left--;
                    if (left == 0) begin
                        chk("digits_seen", 32'(seen), 32'h7);
                        chk("seg_d2", 32'(cap[2]), 32'(cur.s2));
                        chk("seg_d1", 32'(cap[1]), 32'(cur.s1));
                        chk("seg_d0", 32'(cap[0]), 32'(cur.s0));
                    end
                end
                if (busy) begin
                    bcnt++;
                end else if (bcnt > 0) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_commit", 32'(bcnt), 32'd0);
                    end else begin
                        cur = sbq.pop_front();
                        chk("busy_cycles", 32'(bcnt), 32'd9);
                        chk("leds", 32'(leds), 32'(cur.leds));
                        if (cur.chk_disp) begin
                            left = 12;
                            seen = '0;
                        end
                    end
                    bcnt = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [2:0] ian  [3];
        logic [6:0] iseg [3];
        logic [6:0] cap  [3];
        ian  = '{3'b110, 3'b101, 3'b011};
        iseg = '{7'h40, 7'h7F, 7'h7F};

        rst_n = 1'b0; load = 1'b0; resultado = '0; banderas = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_an",   32'(an),   32'h7);
        chk("rst_seg",  32'(seg),  32'h7F);
        chk("rst_leds", 32'(leds), 32'h0);

        // Idle scan after release: "0" on digit 0, other digits blanked.
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("idle_an",  32'(an),  32'(ian[i/4]));
            chk("idle_seg", 32'(seg), 32'(iseg[i/4]));
        end

        push_exp(4'b1010, 7'h24, 7'h12, 7'h12, 1'b1);
        do_load(8'd255, 4'b1010);
        repeat (30) @(negedge clk);

        push_exp(4'b0001, 7'h7F, 7'h7F, 7'h78, 1'b1);
        do_load(8'd7, 4'b0001);
        repeat (30) @(negedge clk);

        push_exp(4'b0101, 7'h7F, 7'h7F, 7'h40, 1'b1);
        do_load(8'd0, 4'b0101);
        repeat (30) @(negedge clk);

        // Second load arrives during CONVERT and must be dropped.
        push_exp(4'b0110, 7'h24, 7'h40, 7'h40, 1'b1);
        do_load(8'd200, 4'b0110);
        @(negedge clk);
        load = 1'b1; resultado = 8'd99; banderas = 4'b1111;
        @(negedge clk);
        load = 1'b0;
        repeat (30) @(negedge clk);

        // Asynchronous reset in the middle of a conversion.
        do_load(8'd128, 4'b0011);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_an",   32'(an),   32'h7);
        chk("midrst_seg",  32'(seg),  32'h7F);
        chk("midrst_leds", 32'(leds), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cap = '{7'h55, 7'h55, 7'h55};
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            case (an)
                3'b110:  cap[0] = seg;
                3'b101:  cap[1] = seg;
                3'b011:  cap[2] = seg;
                default: ;
            endcase
        end
        chk("postrst_d0",   32'(cap[0]), 32'h40);
        chk("postrst_d1",   32'(cap[1]), 32'h7F);
        chk("postrst_d2",   32'(cap[2]), 32'h7F);
        chk("postrst_leds", 32'(leds),   32'h0);
        chk("postrst_busy", 32'(busy),   32'd0);

        // Back-to-back: second load on the first IDLE cycle after DONE.
        push_exp(4'b1001, 7'h7F, 7'h7F, 7'h7F, 1'b0);
        push_exp(4'b1100, 7'h7F, 7'h79, 7'h30, 1'b1);
        @(negedge clk);
        load = 1'b1; resultado = 8'd42; banderas = 4'b1001;
        @(negedge clk);
        load = 1'b0;
        repeat (9) @(negedge clk);
        load = 1'b1; resultado = 8'd13; banderas = 4'b1100;
        @(negedge clk);
        load = 1'b0;
        repeat (30) @(negedge clk);

        chk("sb_drain", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
